// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch sequencer: run/pause/adjust modes over BCD counters,
// with blink-driven per-field blanking for the display mux.
module stopwatch_ctrl #(
  parameter int unsigned MIN_LIMIT = 99,
  parameter int unsigned SEC_LIMIT = 59
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_4hz,
  input  logic       pause_p,
  input  logic       clr_p,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blank_min,
  output logic       blank_sec
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned FIELD_W = 2 * DIGIT_W;

  localparam logic [FIELD_W-1:0] MIN_LIM = {DIGIT_W'(MIN_LIMIT / 10), DIGIT_W'(MIN_LIMIT % 10)};
  localparam logic [FIELD_W-1:0] SEC_LIM = {DIGIT_W'(SEC_LIMIT / 10), DIGIT_W'(SEC_LIMIT % 10)};

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_ADJ   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [FIELD_W-1:0] min_q, min_d;
  logic [FIELD_W-1:0] sec_q, sec_d;
  logic               phase_q, phase_d;

  // Two-digit BCD increment that wraps to 00 after the field limit.
  function automatic logic [FIELD_W-1:0] bcd_inc(input logic [FIELD_W-1:0] v,
                                                 input logic [FIELD_W-1:0] lim);
    if (v == lim)
      return '0;
    else if (v[DIGIT_W-1:0] == DIGIT_W'(9))
      return {v[FIELD_W-1:DIGIT_W] + DIGIT_W'(1), DIGIT_W'(0)};
    else
      return {v[FIELD_W-1:DIGIT_W], v[DIGIT_W-1:0] + DIGIT_W'(1)};
  endfunction

  // Next-state/datapath: clear beats adjust beats per-mode behaviour.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    phase_d = phase_q;

    if (clr_p) begin
      min_d = '0;
      sec_d = '0;
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (adj) begin
      if (state_q != ST_ADJ) begin
        state_d = ST_ADJ;
        phase_d = 1'b0;
      end else begin
        if (tick_2hz) begin
          if (sel) sec_d = bcd_inc(sec_q, SEC_LIM);
          else     min_d = bcd_inc(min_q, MIN_LIM);
        end
        if (tick_4hz) phase_d = ~phase_q;
      end
    end else begin
      case (state_q)
        ST_ADJ:   state_d = ST_PAUSE;
        ST_PAUSE: if (pause_p) state_d = ST_RUN;
        ST_RUN: begin
          // Increment lands before a same-cycle pause takes effect.
          if (tick_1hz) begin
            sec_d = bcd_inc(sec_q, SEC_LIM);
            if (sec_q == SEC_LIM) min_d = bcd_inc(min_q, MIN_LIM);
          end
          if (pause_p) state_d = ST_PAUSE;
        end
        default:  state_d = ST_PAUSE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_PAUSE;
      min_q     <= '0;
      sec_q     <= '0;
      phase_q   <= 1'b0;
      running   <= 1'b0;
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      phase_q   <= phase_d;
      running   <= (state_d == ST_RUN);
      blank_min <= (state_d == ST_ADJ) & ~sel & phase_d;
      blank_sec <= (state_d == ST_ADJ) &  sel & phase_d;
    end
  end

  assign min_tens = min_q[FIELD_W-1:DIGIT_W];
  assign min_ones = min_q[DIGIT_W-1:0];
  assign sec_tens = sec_q[FIELD_W-1:DIGIT_W];
  assign sec_ones = sec_q[DIGIT_W-1:0];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed plus random bench for stopwatch_ctrl against an integer
// minutes/seconds reference model.
module tb_stopwatch_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick_1hz, tick_2hz, tick_4hz, pause_p, clr_p, adj, sel;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, blank_min, blank_sec;

  int errors = 0;
  int checks = 0;

  localparam int M_PAUSE = 0;
  localparam int M_RUN   = 1;
  localparam int M_ADJ   = 2;

  int mode, mm, ss, ph;
  logic exp_bmin, exp_bsec;

  stopwatch_ctrl dut (
    .clock(clock), .reset(reset),
    .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_4hz(tick_4hz),
    .pause_p(pause_p), .clr_p(clr_p), .adj(adj), .sel(sel),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .blank_min(blank_min), .blank_sec(blank_sec)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [15:0] model_disp();
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_reset();
    mode = M_PAUSE; mm = 0; ss = 0; ph = 0;
    exp_bmin = 1'b0; exp_bsec = 1'b0;
  endtask

  // Reference behaviour for one clock edge, from the current inputs.
  task automatic model_edge();
    int total;
    if (clr_p) begin
      mm = 0; ss = 0;
      if (mode == M_RUN) mode = M_PAUSE;
    end else if (adj) begin
      if (mode != M_ADJ) begin
        mode = M_ADJ; ph = 0;
      end else begin
        if (tick_2hz) begin
          if (sel) ss = (ss == 59) ? 0 : ss + 1;
          else     mm = (mm == 99) ? 0 : mm + 1;
        end
        if (tick_4hz) ph = 1 - ph;
      end
    end else if (mode == M_ADJ) begin
      mode = M_PAUSE;
    end else if (mode == M_PAUSE) begin
      if (pause_p) mode = M_RUN;
    end else begin
      if (tick_1hz) begin
        total = (mm * 60 + ss + 1) % 6000;
        mm = total / 60;
        ss = total % 60;
      end
      if (pause_p) mode = M_PAUSE;
    end
    exp_bmin = (mode == M_ADJ) && !sel && (ph == 1);
    exp_bsec = (mode == M_ADJ) &&  sel && (ph == 1);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_disp"}, disp(), model_disp());
    chk({tag, "_run"},  16'(running),   16'(mode == M_RUN));
    chk({tag, "_bmin"}, 16'(blank_min), 16'(exp_bmin));
    chk({tag, "_bsec"}, 16'(blank_sec), 16'(exp_bsec));
  endtask

  // One clock: drive pulses/levels, advance model, sample 1 time unit after the edge.
  task automatic step(input string tag, input logic p, input logic c, input logic a,
                      input logic s, input logic t1, input logic t2, input logic t4);
    pause_p = p; clr_p = c; adj = a; sel = s;
    tick_1hz = t1; tick_2hz = t2; tick_4hz = t4;
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
    pause_p = 0; clr_p = 0; tick_1hz = 0; tick_2hz = 0; tick_4hz = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #12;
    model_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Load mm:ss via ADJ from the current state, then release adj.
  task automatic preload(input int m, input int s);
    step("pre_clr", 0, 1, 0, 0, 0, 0, 0);
    step("pre_ent", 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < m; i++) step("pre_min", 0, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < s; i++) step("pre_sec", 0, 0, 1, 1, 0, 1, 0);
    step("pre_rel", 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic a_lvl, s_lvl;
    reset = 1'b0; tick_1hz = 0; tick_2hz = 0; tick_4hz = 0;
    pause_p = 0; clr_p = 0; adj = 0; sel = 0;
    @(negedge clock);
    do_reset();
    chk("reset_disp", disp(), 16'h0000);
    chk("reset_run", 16'(running), 16'h0);
    chk("reset_blank", {14'h0, blank_min, blank_sec}, 16'h0);

    // Plan 1: run 61 seconds, pause, ticks ignored.
    step("p1_start", 1, 0, 0, 0, 0, 0, 0);
    chk("p1_running", 16'(running), 16'h1);
    for (int i = 0; i < 61; i++) step("p1_tick", 0, 0, 0, 0, 1, 0, 0);
    chk("p1_0101", disp(), 16'h0101);
    step("p1_pause", 1, 0, 0, 0, 0, 0, 0);
    chk("p1_stopped", 16'(running), 16'h0);
    for (int i = 0; i < 5; i++) step("p1_idle", 0, 0, 0, 0, 1, 0, 0);
    chk("p1_hold", disp(), 16'h0101);

    // Plan 2: 99:58 rolls over to 00:00.
    preload(99, 58);
    chk("p2_load", disp(), 16'h9958);
    step("p2_run", 1, 0, 0, 0, 0, 0, 0);
    step("p2_t1", 0, 0, 0, 0, 1, 0, 0);
    chk("p2_9959", disp(), 16'h9959);
    step("p2_t2", 0, 0, 0, 0, 1, 0, 0);
    chk("p2_wrap", disp(), 16'h0000);
    chk("p2_blank", {14'h0, blank_min, blank_sec}, 16'h0);

    // Plan 3: seconds adjust wraps without carry; tick_1hz ignored in ADJ.
    preload(7, 58);
    step("p3_ent", 0, 0, 1, 1, 0, 0, 0);
    step("p3_a", 0, 0, 1, 1, 0, 1, 0);
    chk("p3_59", disp(), 16'h0759);
    step("p3_b", 0, 0, 1, 1, 1, 1, 0);
    chk("p3_00", disp(), 16'h0700);
    step("p3_c", 0, 0, 1, 1, 1, 1, 0);
    chk("p3_01", disp(), 16'h0701);

    // Plan 4: blink on minutes, move to seconds, leave ADJ.
    step("p4_sel0", 0, 0, 1, 0, 0, 0, 0);
    step("p4_rel", 0, 0, 0, 0, 0, 0, 0);
    step("p4_ent", 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step("p4_blink", 0, 0, 1, 0, 0, 0, 1);
      chk("p4_bmin", 16'(blank_min), 16'(i % 2 == 0));
      chk("p4_bsec0", 16'(blank_sec), 16'h0);
    end
    step("p4_on", 0, 0, 1, 0, 0, 0, 1);
    step("p4_sel1", 0, 0, 1, 1, 0, 0, 0);
    chk("p4_moved", {14'h0, blank_min, blank_sec}, 16'h1);
    step("p4_drop", 0, 0, 0, 1, 0, 0, 0);
    chk("p4_off", {14'h0, blank_min, blank_sec}, 16'h0);

    // Plan 5: pause+tick in RUN, then pause+tick in PAUSE.
    preload(0, 0);
    step("p5_run", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step("p5_tick", 0, 0, 0, 0, 1, 0, 0);
    step("p5_both", 1, 0, 0, 0, 1, 0, 0);
    chk("p5_0010", disp(), 16'h0010);
    chk("p5_paused", 16'(running), 16'h0);
    step("p5_both2", 1, 0, 0, 0, 1, 0, 0);
    chk("p5_hold", disp(), 16'h0010);
    chk("p5_resumed", 16'(running), 16'h1);

    // Plan 6: clear wins over tick; async reset mid-ADJ.
    preload(12, 34);
    step("p6_run", 1, 0, 0, 0, 0, 0, 0);
    step("p6_clr", 0, 1, 0, 0, 1, 0, 0);
    chk("p6_zero", disp(), 16'h0000);
    chk("p6_paused", 16'(running), 16'h0);
    preload(3, 21);
    step("p6_ent", 0, 0, 1, 1, 0, 0, 0);
    step("p6_blink", 0, 0, 1, 1, 0, 0, 1);
    chk("p6_preblank", 16'(blank_sec), 16'h1);
    adj = 1; sel = 1;
    #1 reset = 1'b1;
    #1;
    chk("p6_async_disp", disp(), 16'h0000);
    chk("p6_async_blank", {14'h0, blank_min, blank_sec}, 16'h0);
    reset = 1'b0;
    model_reset();
    adj = 0; sel = 0;
    @(posedge clock);
    #1;

    // Randomised stretch against the model.
    a_lvl = 0; s_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) a_lvl = ~a_lvl;
      if ($urandom_range(0, 9) == 0)  s_lvl = ~s_lvl;
      step("rnd", $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0, a_lvl, s_lvl,
           $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller for the stopwatch's time-keeping datapath. Consumes single-cycle tick enables from the clock divider: 1 Hz counting, 2 Hz adjust rate, 4 Hz blink rate. Runs the MM:SS BCD counters through run, pause and adjust modes and drives per-field blank flags for the display multiplexer. All logic runs on the 100 MHz master clock; ticks are enables, never clocks.

Parameters:
MIN_LIMIT, 99, highest minutes value; wraps to 0 after it.
SEC_LIMIT, 59, highest seconds value; wraps to 0 after it.

Ports:
clock  input  1  master clock; every register on its rising edge.
reset  input  1  asynchronous, active-high reset.
tick_1hz  input  1  one-cycle count enable, 1 Hz.
tick_2hz  input  1  one-cycle adjust enable, 2 Hz.
tick_4hz  input  1  one-cycle blink enable, 4 Hz.
pause_p  input  1  one-cycle debounced pause-button pulse.
clr_p  input  1  one-cycle debounced clear-button pulse.
adj  input  1  adjust-mode switch (level).
sel  input  1  adjust field select: 0 = minutes, 1 = seconds.
min_tens  output  4  BCD minutes tens digit.
min_ones  output  4  BCD minutes ones digit.
sec_tens  output  4  BCD seconds tens digit, 0..5.
sec_ones  output  4  BCD seconds ones digit.
running  output  1  high in RUN.
blank_min  output  1  display blanks minutes digits when high.
blank_sec  output  1  display blanks seconds digits when high.

Behaviour:
- Reset (async): all digits 0, state PAUSE, running=0, blank_min=blank_sec=0, blink phase 0.
- Outputs are registered. A qualifying event at edge N is visible after edge N; no other latency.
- States: PAUSE, RUN, ADJ. Encoding is free; running is decoded as a registered value.
- Evaluation priority each cycle, highest first:
  - clr_p: all digits → 0. State is unchanged except RUN → PAUSE. All other events that cycle are ignored.
  - adj=1: from any state go to or stay in ADJ.
- PAUSE:
  - pause_p with adj=0 → RUN.
  - tick_1hz is ignored.
  - pause_p and tick_1hz in the same cycle → RUN with no increment that cycle.
- RUN:
  - tick_1hz increments seconds.
  - sec_ones 9→0 carries into sec_tens.
  - Seconds SEC_LIMIT→0 carries +1 into minutes.
  - Minutes MIN_LIMIT→0 with no further carry, so 99:59 → 00:00.
  - pause_p → PAUSE. If tick_1hz arrives the same cycle, the increment is applied first, then PAUSE.
- ADJ:
  - Each tick_2hz increments only the sel field by 1 with BCD wrap: minutes MIN_LIMIT→0, seconds SEC_LIMIT→0.
  - No carry between fields.
  - tick_1hz and pause_p are ignored.
  - sel is sampled on the tick_2hz cycle.
  - adj falling → PAUSE, whatever the previous state was. Digits are retained.
- Blink:
  - Blink phase resets to 0 on ADJ entry and toggles on each tick_4hz while in ADJ.
  - blank_min = ADJ & ~sel & phase; blank_sec = ADJ & sel & phase.
  - Both are 0 outside ADJ.
  - A sel change mid-ADJ moves the blank to the other field immediately (next edge); phase is not reset.
- Simultaneous ticks are common (1/2/4 Hz are aligned). Each input is honoured only in the states above; the result never depends on tick order.
- Invariants: digits always valid BCD; sec_tens ≤ 5; minutes ≤ MIN_LIMIT; seconds ≤ SEC_LIMIT.
- Reset asserted mid-count or mid-ADJ returns to the reset values immediately (asynchronously).

Test Plan:
1. Reset, then pause_p, then 61 tick_1hz → running=1, display 01:01; pause_p → running=0; 5 more ticks → still 01:01.
2. Preload via ADJ to 99:58, drop adj, pause_p, 2 tick_1hz → 00:00 after the second tick; blank flags 0.
3. adj=1, sel=1, seconds at 58, 3 tick_2hz → seconds 59, 00, 01; minutes unchanged (no carry). Same cycle as a tick_1hz → no extra increment.
4. In ADJ with sel=0, 4 tick_4hz → blank_min toggles 1,0,1,0 and blank_sec stays 0; switch sel=1 → blank_sec=1 next edge; drop adj → PAUSE, both blanks 0.
5. In RUN at 00:09, pause_p and tick_1hz in the same cycle → 00:10 and PAUSE. In PAUSE, pause_p and tick_1hz together → RUN, display still 00:10.
6. In RUN at 12:34, clr_p together with tick_1hz → 00:00, PAUSE. Async reset pulse mid-ADJ between clock edges → digits 0 and blanks 0 before the next edge.
